// File: rtl/cnn_layer_accel_wseq_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_wseq_pkg
// Shared definitions for the QUAD weight sequencer:
//   SEQ_LEN / SEQ_ADDR_W : length and index width of the weight sequence
//   wseq_state_t         : sequencer control states
//   gray2_next()         : one step of the 2-bit Gray sequence 00->01->11->10->00
// -----------------------------------------------------------------------------
package cnn_layer_accel_wseq_pkg;

  localparam int SEQ_LEN    = 5;
  localparam int SEQ_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wseq_state_t;

  function automatic logic [1:0] gray2_next(input logic [1:0] g);
    logic [1:0] n;
    case (g)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_counter2.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_gray_counter2
// 2-bit Gray counter that steps 00->01->11->10->00 and wraps.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (count -> 00)
//   clr_i  : synchronous clear (count -> 00), takes priority over en_i
//   en_i   : advance one Gray step
//   gray_o : current Gray count
// -----------------------------------------------------------------------------
module cnn_layer_accel_gray_counter2
  import cnn_layer_accel_wseq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] gray_o
);

  logic [1:0] gray_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      gray_q <= 2'b00;
    end else if (en_i) begin
      gray_q <= gray2_next(gray_q);
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_weight_sequencer
// Walks the 5-entry weight sequence for every (row, column) position of a
// convolution window pass and drives the QUAD weight sequence table.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : pass request, sampled only in IDLE
//   num_rows/num_cols : pass dimensions, latched at start
//   stall             : hold the sequence, suppress issue (RUN only)
//   gray_code         : Gray-coded row phase
//   sequence_selector : column parity (1 on even columns)
//   seq_data_addr     : sequence index 0..4
//   seq_valid         : tuple on the table inputs is a new issue
//   wht_valid         : seq_valid delayed one cycle, qualifies wht_data_addr
//   busy              : pass in progress (RUN or DRAIN)
//   done              : one-cycle pulse at pass completion
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cnn_layer_accel_weight_sequencer
  import cnn_layer_accel_wseq_pkg::*;
#(
  parameter int ROW_W = 10,
  parameter int COL_W = 10
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_W-1:0]      num_rows,
  input  logic [COL_W-1:0]      num_cols,
  input  logic                  stall,
  output logic [1:0]            gray_code,
  output logic                  sequence_selector,
  output logic [SEQ_ADDR_W-1:0] seq_data_addr,
  output logic                  seq_valid,
  output logic                  wht_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEQ_ADDR_W-1:0] ADDR_LAST = SEQ_ADDR_W'(SEQ_LEN - 1);

  wseq_state_t           state_q, state_d;
  logic [ROW_W-1:0]      rows_q, rows_d;
  logic [COL_W-1:0]      cols_q, cols_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [SEQ_ADDR_W-1:0] addr_q, addr_d;
  logic                  sel_q, sel_d;
  logic                  seq_valid_q, seq_valid_d;
  logic                  wht_valid_q;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  gray_clr, gray_en;
  logic [1:0]            gray_q;

  logic last_addr, last_col, last_row, is_last, zero_cnt;

  // Counters are compared against the latched count minus one; zero counts
  // never reach RUN, so the subtraction cannot wrap while it matters.
  assign last_addr = (addr_q == ADDR_LAST);
  assign last_col  = (col_q == cols_q - COL_W'(1));
  assign last_row  = (row_q == rows_q - ROW_W'(1));
  assign is_last   = last_addr && last_col && last_row;
  assign zero_cnt  = (num_rows == '0) || (num_cols == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = zero_cnt ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (!stall && is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rows_d      = rows_q;
    cols_d      = cols_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    seq_valid_d = 1'b0;
    gray_clr    = 1'b0;
    gray_en     = 1'b0;
    // busy and done are registered views of where the FSM is heading, so
    // they line up with the state they describe.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DRAIN);

    case (state_q)
      IDLE: begin
        if (start) begin
          rows_d   = num_rows;
          cols_d   = num_cols;
          row_d    = '0;
          col_d    = '0;
          addr_d   = '0;
          gray_clr = 1'b1;
          if (!zero_cnt) begin
            sel_d       = 1'b1;
            seq_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A stalled cycle keeps every counter; the tuple already issued is
        // not re-issued when the stall drops, the next one is.
        if (!stall && !is_last) begin
          seq_valid_d = 1'b1;
          if (last_addr) begin
            addr_d = '0;
            if (last_col) begin
              col_d   = '0;
              sel_d   = 1'b1;
              row_d   = row_q + ROW_W'(1);
              gray_en = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
              sel_d = ~sel_q;
            end
          end else begin
            addr_d = addr_q + SEQ_ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      sel_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      wht_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      seq_valid_q <= seq_valid_d;
      wht_valid_q <= seq_valid_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  cnn_layer_accel_gray_counter2 u_gray (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (gray_clr),
    .en_i   (gray_en),
    .gray_o (gray_q)
  );

  assign gray_code         = gray_q;
  assign sequence_selector = sel_q;
  assign seq_data_addr     = addr_q;
  assign seq_valid         = seq_valid_q;
  assign wht_valid         = wht_valid_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cnn_layer_accel_weight_sequencer. A beat-index
// reference model predicts every output each cycle; a single compare process
// checks the DUT on the falling edge, plus a few literal per-pass figures.
// -----------------------------------------------------------------------------
module tb_cnn_layer_accel_weight_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] num_rows = '0;
  logic [9:0] num_cols = '0;
  logic [1:0] gray_code;
  logic       sequence_selector;
  logic [2:0] seq_data_addr;
  logic       seq_valid, wht_valid, busy, done;

  always #5 clk = ~clk;

  cnn_layer_accel_weight_sequencer #(.ROW_W(10), .COL_W(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_rows          (num_rows),
    .num_cols          (num_cols),
    .stall             (stall),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .seq_valid         (seq_valid),
    .wht_valid         (wht_valid),
    .busy              (busy),
    .done              (done)
  );

  int total = 0;
  int bad   = 0;

  // Driver-owned expectations and flags, read by the compare process.
  logic timeout_flag = 1'b0;
  int   lit_beats = -1;
  int   lit_lat   = -1;
  logic lit_sweep = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model: a pass is the list of 5*R*C beats; beat k belongs to
  // row k/(5C), column (k/5)%C, index k%5.
  // ---------------------------------------------------------------------------
  logic       m_sv = 1'b0, m_wv = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic       m_chk_tuple = 1'b1, m_start_pulse = 1'b0;
  logic [1:0] m_gray = '0;
  logic       m_sel = 1'b0;
  logic [2:0] m_addr = '0;
  int         m_idx = 0, m_total = 0, m_R = 0, m_C = 0;

  function automatic void tuple_of(input int k, input int R, input int C,
                                   output logic [1:0] g, output logic s,
                                   output logic [2:0] a);
    int r, c;
    r = k / (5 * C);
    c = (k / 5) % C;
    a = 3'(k % 5);
    s = ((c % 2) == 0);
    g = 2'((r % 4) ^ ((r % 4) >> 1));
    if (R < 0) s = 1'bx;  // R only bounds k; never negative here
  endfunction

  always @(posedge clk) begin
    m_start_pulse = 1'b0;
    if (rst) begin
      m_sv = 0; m_wv = 0; m_busy = 0; m_done = 0;
      m_gray = '0; m_sel = 1'b0; m_addr = '0; m_chk_tuple = 1'b1;
    end else begin
      m_wv = m_sv;
      if (m_busy && m_done) begin
        m_busy = 0; m_done = 0; m_sv = 0;
      end else if (!m_busy) begin
        m_sv = 0;
        if (start) begin
          m_R = int'(num_rows);
          m_C = int'(num_cols);
          m_total = 5 * m_R * m_C;
          m_busy = 1;
          m_start_pulse = 1;
          m_chk_tuple = 0;
          if (m_total == 0) begin
            m_done = 1;
          end else begin
            m_idx = 0;
            m_sv = 1;
            tuple_of(0, m_R, m_C, m_gray, m_sel, m_addr);
          end
        end
      end else begin
        if (stall) begin
          m_sv = 0;
        end else if (m_idx == m_total - 1) begin
          m_sv = 0;
          m_done = 1;
        end else begin
          m_idx++;
          m_sv = 1;
          tuple_of(m_idx, m_R, m_C, m_gray, m_sel, m_addr);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  int pass_beats = 0;
  int pass_cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_start_pulse) begin
      pass_beats = 0;
      pass_cyc   = 0;
    end
    pass_cyc++;
    chk("seq_valid", int'(seq_valid), int'(m_sv));
    chk("wht_valid", int'(wht_valid), int'(m_wv));
    chk("busy",      int'(busy),      int'(m_busy));
    chk("done",      int'(done),      int'(m_done));
    chk("timeout",   int'(timeout_flag), 0);
    if (m_sv || m_chk_tuple) begin
      chk("gray_code", int'(gray_code), int'(m_gray));
      chk("sequence_selector", int'(sequence_selector), int'(m_sel));
      chk("seq_data_addr", int'(seq_data_addr), int'(m_addr));
    end
    if (seq_valid) begin
      if (pass_beats == 3) chk("beat3_addr", int'(seq_data_addr), 3);
      if (lit_sweep) begin
        case (pass_beats)
          5:  chk("sweep_b5_sel", int'(sequence_selector), 0);
          15: chk("sweep_b15_gray", int'(gray_code), 1);
          45: chk("sweep_b45_gray", int'(gray_code), 2);
          60: chk("sweep_b60_gray", int'(gray_code), 0);
          default: ;
        endcase
      end
      pass_beats++;
    end
    if (done) begin
      if (lit_beats >= 0) chk("pass_beats", pass_beats, lit_beats);
      if (lit_lat >= 0)   chk("done_latency", pass_cyc, lit_lat);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // stall_mode: 0 none, 1 random, 2 three cycles after the first addr=2 beat
  // ---------------------------------------------------------------------------
  task automatic run_pass(input int R, input int C, input int stall_mode,
                          input int mid_start, input int exp_beats,
                          input int exp_lat);
    int   n, st_cnt;
    logic seen, stalled_once;
    lit_beats = exp_beats;
    lit_lat   = exp_lat;
    num_rows  = 10'(R);
    num_cols  = 10'(C);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    seen = 0; n = 0; st_cnt = 0; stalled_once = 0;
    while (!seen && n < 5 * R * C * 4 + 40) begin
      if (done) begin
        seen = 1;
      end else begin
        case (stall_mode)
          1: stall = ($urandom_range(0, 3) == 0);
          2: begin
            if (st_cnt > 0) begin
              if (st_cnt < 3) st_cnt++;
              else begin stall = 1'b0; st_cnt = 0; end
            end else if (!stalled_once && seq_valid && seq_data_addr == 3'd2) begin
              stall = 1'b1; st_cnt = 1; stalled_once = 1;
            end
          end
          default: stall = 1'b0;
        endcase
        if (n == mid_start) begin
          start = 1'b1; num_rows = 10'd4; num_cols = 10'd4;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!seen) timeout_flag = 1'b1;
    stall = 1'b0;
    start = 1'b0;
    @(negedge clk);
    $display("pass R=%0d C=%0d stall_mode=%0d finished_in=%0d", R, C, stall_mode, n);
  endtask

  initial begin
    int R, C;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_pass(1, 1, 0, -1, 5, 6);
    lit_sweep = 1'b1;
    run_pass(5, 3, 0, -1, 75, 76);
    lit_sweep = 1'b0;
    run_pass(1, 2, 2, -1, 10, 14);
    run_pass(0, 3, 0, -1, 0, 1);
    run_pass(4, 0, 0, -1, 0, 1);
    run_pass(2, 2, 0, 7, 20, 21);   // start pulsed mid-pass is ignored
    run_pass(1, 1, 0, -1, 5, 6);    // accepted at the earliest edge

    // Abandon a pass with reset, then restart.
    lit_beats = -1;
    lit_lat   = -1;
    num_rows  = 10'd3;
    num_cols  = 10'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("pass R=3 C=3 abandoned by reset");
    run_pass(1, 1, 0, -1, 5, 6);

    for (int i = 0; i < 10; i++) begin
      R = int'($urandom_range(0, 4));
      C = int'($urandom_range(0, 4));
      run_pass(R, C, 1, -1, 5 * R * C, -1);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
